cache_dados: RTL and testbench
==============================

CACHE_DADOS -- requirements
Module: cache_dados

Interface
Parameters:
REQ-001 SHALL have parameter INDEX_BITS, default 4, giving the number of index bits (2^INDEX_BITS lines).
REQ-002 SHALL have parameter ADDR_BITS, default 12, giving the word-address width; tag width = ADDR_BITS-INDEX_BITS.

Ports:
REQ-003 SHALL have one clock; reset is synchronous and active-high (ports clk and rst; polarity and synchronicity fixed).
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 address  in  12  CPU word address, valid with r_en/w_en.
REQ-007 data  in  32  CPU store data, valid with w_en.
REQ-008 r_en  in  1  CPU load request, one-cycle pulse.
REQ-009 w_en  in  1  CPU store request, one-cycle pulse.
REQ-010 stall  out  1  busy; CPU holds in memory stage while 1.
REQ-011 saida_cache  out  32  load result, valid from the cycle stall is 0 after a load.
REQ-012 mem_address  out  12  backing-memory address.
REQ-013 mem_wdata  out  32  backing-memory write data.
REQ-014 mem_r_en  out  1  backing-memory read strobe, held until mem_ready.
REQ-015 mem_w_en  out  1  backing-memory write strobe, held until mem_ready.
REQ-016 mem_rdata  in  32  backing-memory read data, valid with mem_ready.
REQ-017 mem_ready  in  1  backing memory completed current access.
REQ-018 hit_count  out  16  saturating count of load and store hits.
REQ-019 miss_count  out  16  saturating count of load and store misses.

Function
REQ-020 SHALL be direct-mapped, one 32-bit word per line; index = address[INDEX_BITS-1:0], tag = address[ADDR_BITS-1:INDEX_BITS]; per line: valid bit, tag, data.
REQ-021 SHALL use FSM states IDLE, READ_MISS, WRITE_MEM; only IDLE accepts requests.
REQ-022 A request is accepted at the rising edge when state=IDLE and r_en or w_en is 1; it SHALL latch address and data internally.
REQ-023 If r_en and w_en are both 1, w_en SHALL take priority and r_en SHALL be ignored.
REQ-024 Hit = line valid and stored tag equals request tag, evaluated combinationally in IDLE.
REQ-025 Load hit: at the accept edge, saida_cache <= line data; stall stays 0; state stays IDLE (latency 1 cycle).
REQ-026 Load miss: at the accept edge, state <= READ_MISS; stall <= 1; mem_r_en <= 1; mem_address <= address.
REQ-027 In READ_MISS with mem_ready=1: write line (valid=1, tag, mem_rdata); saida_cache <= mem_rdata; mem_r_en <= 0; stall <= 0; state <= IDLE.
REQ-028 Store (write-through, no write-allocate): at the accept edge, state <= WRITE_MEM; stall <= 1; mem_w_en <= 1; mem_address <= address; mem_wdata <= data; on hit, line data <= data in the same edge; on miss, the line is unchanged.
REQ-029 In WRITE_MEM with mem_ready=1: mem_w_en <= 0; stall <= 0; state <= IDLE.
REQ-030 r_en/w_en arriving while state is not IDLE SHALL be ignored (no latch, no count).
REQ-031 mem_ready while state=IDLE SHALL be ignored.
REQ-032 hit_count/miss_count SHALL increment by 1 at each accept edge per outcome; saturate at 16'hFFFF (no wrap).
REQ-033 mem_r_en and mem_w_en SHALL never be 1 simultaneously.
REQ-034 saida_cache SHALL hold its value except on load hit or load-miss completion.

Reset
REQ-035 rst=1 at a rising edge SHALL: state <= IDLE; stall, mem_r_en, mem_w_en <= 0; saida_cache, mem_address, mem_wdata <= 0; hit_count, miss_count <= 0; all valid bits <= 0.
REQ-036 rst overrides everything, including mid-miss or mid-write; the in-flight request is dropped, and no line is filled from a mem_ready arriving in the same edge as rst.
REQ-037 Line tag/data contents need not be cleared by rst.

Verification
REQ-038 After reset, load address 12'h025 with memory returning 32'hDEADBEEF after 3 cycles -> stall 1 for 4 cycles, then saida_cache=32'hDEADBEEF, miss_count=1.
REQ-039 Repeat load 12'h025 -> stall stays 0, saida_cache=32'hDEADBEEF next cycle, hit_count=1, no mem_r_en.
REQ-040 Store 32'h12345678 to 12'h025, then load 12'h025 -> mem_w_en with mem_wdata=32'h12345678 until mem_ready; the load hits returning 32'h12345678.
REQ-041 Load 12'h035 (same index 5, different tag) -> miss, line replaced; load 12'h025 -> miss again; miss_count increments each time.
REQ-042 Store miss to 12'h0F0 then load 12'h0F0 -> store does not allocate, load misses (miss_count +2).
REQ-043 Assert rst during READ_MISS together with mem_ready=1 -> all outputs 0, state IDLE, next load to that address misses.

Source files
------------

// File: rtl/cache_dados.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// It connects the CPU to a handshaked backing memory and keeps saturating hit/miss counters.
module cache_dados #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [31:0]          data,
  input  logic                 r_en,
  input  logic                 w_en,
  output logic                 stall,
  output logic [31:0]          saida_cache,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [31:0]          mem_wdata,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int DATA_W = 32;
  localparam int TAG_W  = ADDR_BITS - INDEX_BITS;
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE_MEM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [DATA_W-1:0] r_data_mem [LINES];

  logic                 r_stall;
  logic [DATA_W-1:0]    r_saida;
  logic [ADDR_BITS-1:0] r_mem_address;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_mem_r_en;
  logic                 r_mem_w_en;
  logic [CNT_W-1:0]     r_hit_count;
  logic [CNT_W-1:0]     r_miss_count;

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_acc_rd;
  logic                  w_acc_wr;
  logic                  w_fill;
  logic                  w_wr_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_index      = address[INDEX_BITS-1:0];
  assign w_tag        = address[ADDR_BITS-1:INDEX_BITS];
  assign w_hit        = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
  // A pending miss refills the line named by the latched request address.
  assign w_fill_index = r_mem_address[INDEX_BITS-1:0];
  assign w_fill_tag   = r_mem_address[ADDR_BITS-1:INDEX_BITS];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_rd    = 1'b0;
    w_acc_wr    = 1'b0;
    w_fill      = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_en) begin
          w_acc_wr    = 1'b1;
          w_state_nxt = WRITE_MEM;
        end else if (r_en) begin
          w_acc_rd = 1'b1;
          if (!w_hit) w_state_nxt = READ_MISS;
        end
      end
      READ_MISS: begin
        if (mem_ready) begin
          w_fill      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WRITE_MEM: begin
        if (mem_ready) begin
          w_wr_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accept stage: registered handshake, latched request and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall       <= 1'b0;
      r_mem_r_en    <= 1'b0;
      r_mem_w_en    <= 1'b0;
      r_saida       <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
      r_valid       <= '0;
    end else begin
      if (w_acc_wr || w_acc_rd) begin
        if (w_hit) r_hit_count  <= sat_inc(r_hit_count);
        else       r_miss_count <= sat_inc(r_miss_count);
      end
      if (w_acc_wr) begin
        r_stall       <= 1'b1;
        r_mem_w_en    <= 1'b1;
        r_mem_address <= address;
        r_mem_wdata   <= data;
      end else if (w_acc_rd) begin
        if (w_hit) begin
          r_saida <= r_data_mem[w_index];
        end else begin
          r_stall       <= 1'b1;
          r_mem_r_en    <= 1'b1;
          r_mem_address <= address;
        end
      end
      if (w_fill) begin
        r_valid[w_fill_index] <= 1'b1;
        r_saida               <= mem_rdata;
        r_mem_r_en            <= 1'b0;
        r_stall               <= 1'b0;
      end
      if (w_wr_done) begin
        r_mem_w_en <= 1'b0;
        r_stall    <= 1'b0;
      end
    end
  end

  // Line storage: tag/data are not cleared, validity alone gates their use
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_acc_wr && w_hit) r_data_mem[w_index] <= data;
      if (w_fill) begin
        r_tag_mem[w_fill_index]  <= w_fill_tag;
        r_data_mem[w_fill_index] <= mem_rdata;
      end
    end
  end

  assign stall       = r_stall;
  assign saida_cache = r_saida;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign mem_r_en    = r_mem_r_en;
  assign mem_w_en    = r_mem_w_en;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_cache_dados.sv
// Directed bench for cache_dados: drives inputs on the falling edge, checks
// outputs on the following falling edge against hand-computed values.
module tb_cache_dados;

  logic        clk;
  logic        rst;
  logic [11:0] address;
  logic [31:0] data;
  logic        r_en;
  logic        w_en;
  logic        stall;
  logic [31:0] saida_cache;
  logic [11:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;
  int cyc;

  cache_dados #(.INDEX_BITS(4), .ADDR_BITS(12)) dut (
    .clk(clk), .rst(rst), .address(address), .data(data),
    .r_en(r_en), .w_en(w_en), .stall(stall), .saida_cache(saida_cache),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds mem_ready low for lat stall cycles, then presents rdata for one cycle.
  task automatic serve(input int lat, input logic [31:0] rdata, output int n);
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      n++;
      mem_rdata = rdata;
      mem_ready = (n == lat + 1);
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic load(input logic [11:0] a);
    address = a; r_en = 1'b1;
    step();
    r_en = 1'b0;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    address = a; data = d; w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; address = '0; data = '0; r_en = 1'b0; w_en = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_saida", saida_cache, 32'd0);
    chk("reset_mem_en", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    chk("reset_counts", {hit_count, miss_count}, 32'd0);
    chk("reset_mem_addr_wdata", {20'd0, mem_address} | mem_wdata, 32'd0);

    // Cold load miss, memory answers after 3 wait cycles
    load(12'h025);
    chk("miss1_req", {29'd0, stall, mem_r_en, mem_w_en}, 32'b110);
    chk("miss1_addr", {20'd0, mem_address}, 32'h025);
    serve(3, 32'hDEADBEEF, cyc);
    chk("miss1_stall_cycles", cyc, 4);
    chk("miss1_data", saida_cache, 32'hDEADBEEF);
    chk("miss1_counts", {hit_count, miss_count}, {16'd0, 16'd1});
    chk("miss1_rd_drop", {31'd0, mem_r_en}, 32'd0);

    // Repeat load hits with one-cycle latency
    load(12'h025);
    chk("hit1_stall_rd", {30'd0, stall, mem_r_en}, 32'd0);
    chk("hit1_data", saida_cache, 32'hDEADBEEF);
    chk("hit1_counts", {hit_count, miss_count}, {16'd1, 16'd1});

    // Store hit with r_en also high: the write wins
    address = 12'h025; data = 32'h12345678; w_en = 1'b1; r_en = 1'b1;
    step();
    w_en = 1'b0; r_en = 1'b0;
    chk("st_hit_req", {29'd0, stall, mem_r_en, mem_w_en}, 32'b101);
    chk("st_hit_wdata", mem_wdata, 32'h12345678);
    chk("st_hit_addr", {20'd0, mem_address}, 32'h025);
    chk("st_hit_counts", {hit_count, miss_count}, {16'd2, 16'd1});
    serve(2, 32'h0, cyc);
    chk("st_hit_cycles", cyc, 3);
    chk("st_hit_done", {30'd0, stall, mem_w_en}, 32'd0);
    chk("st_hit_saida_hold", saida_cache, 32'hDEADBEEF);
    load(12'h025);
    chk("hit2_data", saida_cache, 32'h12345678);
    chk("hit2_counts", {hit_count, miss_count}, {16'd3, 16'd1});

    // Conflict: same index, different tag evicts and re-misses
    load(12'h035);
    chk("conf_req", {29'd0, stall, mem_r_en, mem_w_en}, 32'b110);
    chk("conf_saida_hold", saida_cache, 32'h12345678);
    serve(1, 32'hCAFEF00D, cyc);
    chk("conf_data", saida_cache, 32'hCAFEF00D);
    chk("conf_counts", {hit_count, miss_count}, {16'd3, 16'd2});
    load(12'h025);
    chk("conf_back_req", {30'd0, stall, mem_r_en}, 32'b11);
    serve(0, 32'h12345678, cyc);
    chk("conf_back_data", saida_cache, 32'h12345678);
    chk("conf_back_counts", {hit_count, miss_count}, {16'd3, 16'd3});

    // Store miss; a load arriving mid-write is ignored
    store(12'h0F0, 32'hA5A5A5A5);
    chk("st_miss_counts", {hit_count, miss_count}, {16'd3, 16'd4});
    chk("st_miss_wdata", mem_wdata, 32'hA5A5A5A5);
    address = 12'h025; r_en = 1'b1;
    step();
    r_en = 1'b0;
    chk("busy_ignore", {29'd0, stall, mem_r_en, mem_w_en}, 32'b101);
    chk("busy_counts", {hit_count, miss_count}, {16'd3, 16'd4});
    chk("busy_addr", {20'd0, mem_address}, 32'h0F0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("st_miss_done", {29'd0, stall, mem_r_en, mem_w_en}, 32'd0);

    // mem_ready while idle changes nothing
    mem_rdata = 32'hFFFFFFFF; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("idle_ready", {31'd0, stall} | (saida_cache ^ 32'h12345678), 32'd0);

    // No write-allocate: load after store miss still misses
    load(12'h0F0);
    chk("noalloc_req", {30'd0, stall, mem_r_en}, 32'b11);
    chk("noalloc_counts", {hit_count, miss_count}, {16'd3, 16'd5});
    serve(0, 32'h55AA55AA, cyc);
    load(12'h0F0);
    chk("noalloc_hit", saida_cache, 32'h55AA55AA);
    chk("noalloc_hit_counts", {hit_count, miss_count}, {16'd4, 16'd5});

    // Reset in READ_MISS coinciding with mem_ready drops the fill
    load(12'h0A7);
    step();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    step();
    rst = 1'b0; mem_ready = 1'b0;
    chk("rst_mid_ctrl", {29'd0, stall, mem_r_en, mem_w_en}, 32'd0);
    chk("rst_mid_saida", saida_cache, 32'd0);
    chk("rst_mid_counts", {hit_count, miss_count}, 32'd0);
    chk("rst_mid_addr", {20'd0, mem_address}, 32'd0);
    load(12'h0A7);
    chk("rst_refetch_req", {30'd0, stall, mem_r_en}, 32'b11);
    chk("rst_refetch_counts", {hit_count, miss_count}, {16'd0, 16'd1});
    serve(0, 32'h22222222, cyc);
    chk("rst_refetch_data", saida_cache, 32'h22222222);
    load(12'h025);
    chk("rst_valid_cleared", {hit_count, miss_count}, {16'd0, 16'd2});
    serve(0, 32'h12345678, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
